// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core slice.
//   - Register file geometry (address width, data width, register count).
//   - State encoding for the register-file dump reader FSM.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    // Dump reader FSM. The encoding is fixed so trace tools can decode it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/register_file.sv
// MIPS register file: two combinational read ports, one write port.
//   clk       : write clock; the write happens on the rising edge
//   we        : write enable for port 3
//   a1 / rd1  : read port 1 address / data (combinational)
//   a2 / rd2  : read port 2 address / data (combinational)
//   a3 / wd3  : write port address / data
// Register 0 always reads as zero.
module register_file
    import mips_pkg::*;
#(
    parameter int ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int DATA_W = mips_pkg::REG_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) regs[a3] <= wd3;
    end

    assign rd1 = (a1 == '0) ? '0 : regs[a1];
    assign rd2 = (a2 == '0) ? '0 : regs[a2];

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader. Walks a wrapping range [first_addr..last_addr]
// of the register file through a spare combinational read port and streams
// each value out on a valid/ready interface tagged with its register index.
//   clk, rst_n                : clock, asynchronous active-low reset
//   start, first_addr,
//   last_addr                 : dump request (sampled only when idle)
//   abort                     : synchronous cancel, no done pulse
//   rf_addr / rf_rd           : register-file read port (registered address)
//   out_valid / out_ready     : beat handshake
//   out_data, out_index,
//   out_last                  : beat payload
//   busy                      : dump in progress
//   done                      : one-cycle pulse after the final beat
module regfile_dump_reader
    import mips_pkg::*;
#(
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int ADDR_W   = mips_pkg::REG_ADDR_W,
    parameter int DATA_W   = mips_pkg::REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] TOP_REG = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state, state_nx;
    logic [ADDR_W-1:0] last_q;
    logic              hs;

    // rf_addr doubles as the walking pointer: it is loaded on start and
    // advanced on each non-final handshake, so it already equals ptr in READ.
    assign hs = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = READ;
            READ: state_nx = abort ? IDLE : SEND;
            SEND: begin
                if (abort)   state_nx = IDLE;
                else if (hs) state_nx = out_last ? FIN : READ;
            end
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_addr   <= '0;
            last_q    <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rf_addr <= first_addr;
                        last_q  <= last_addr;
                        busy    <= 1'b1;
                    end
                end
                READ: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        out_data  <= rf_rd;
                        out_index <= rf_addr;
                        out_last  <= (rf_addr == last_q);
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (abort) begin
                        // A coincident handshake still delivers the beat,
                        // but the dump ends here without a done pulse.
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end else if (hs) begin
                        out_valid <= 1'b0;
                        if (out_last) done <= 1'b1;
                        else rf_addr <= (rf_addr == TOP_REG) ? '0 : rf_addr + ADDR_W'(1);
                    end
                end
                FIN: begin
                    // done was raised on entry; it self-clears via the default.
                    busy      <= 1'b0;
                    out_last  <= 1'b0;
                    out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader driven by the real register file.
module tb_regfile_dump_reader;
    import mips_pkg::*;

    localparam int AW = REG_ADDR_W;
    localparam int DW = REG_DATA_W;
    localparam int NR = NUM_REGS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic          abort = 1'b0;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_rd;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          busy;
    logic          done;

    logic          we = 1'b0;
    logic [AW-1:0] a3 = '0;
    logic [DW-1:0] wd3 = '0;
    logic [DW-1:0] rd2;

    regfile_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr),
        .last_addr(last_addr), .abort(abort), .rf_addr(rf_addr), .rf_rd(rf_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    register_file #(.ADDR_W(AW), .DATA_W(DW)) u_rf (
        .clk(clk), .we(we), .a1(rf_addr), .a2('0), .a3(a3), .wd3(wd3),
        .rd1(rf_rd), .rd2(rd2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] shadow [NR];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            last_done_cyc = 0;
    int            start_cyc = 0;

    function automatic void chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
    end

    // Monitor: every accepted beat is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: index %0d data %0d", out_index, out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_index", DW'(out_index), DW'(e.idx));
                chk("beat_data", out_data, e.data);
                chk("beat_last", DW'(out_last), DW'(e.last));
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rf_write(int idx, logic [DW-1:0] val);
        we = 1'b1; a3 = AW'(idx); wd3 = val;
        tick();
        we = 1'b0;
        shadow[idx] = (idx == 0) ? '0 : val;
    endtask

    // Push expected beats for the range then pulse start for one cycle.
    task automatic start_dump(int f, int l, int push_n = -1);
        int n = ((l - f + NR) % NR) + 1;
        int k = (push_n < 0) ? n : push_n;
        for (int i = 0; i < k; i++) begin
            beat_t b;
            int r = (f + i) % NR;
            b.idx = AW'(r); b.data = shadow[r]; b.last = (i == n - 1);
            exp_q.push_back(b);
        end
        first_addr = AW'(f); last_addr = AW'(l); start = 1'b1;
        tick();
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(string name, int n_beats, bit timed);
        int d0 = done_cnt;
        int lim = 0;
        while (done_cnt == d0 && lim < 400) begin
            tick();
            lim++;
        end
        if (done_cnt == d0) begin
            fail_now({name, "_done"});
        end else begin
            chk({name, "_done_cnt"}, DW'(done_cnt - d0), DW'(1));
            if (timed) chk({name, "_done_cycle"}, DW'(last_done_cyc - start_cyc), DW'(2 * n_beats));
            chk({name, "_busy_after"}, DW'(busy), DW'(0));
            chk({name, "_done_pulse"}, DW'(done), DW'(0));
            chk({name, "_queue_empty"}, DW'(exp_q.size()), DW'(0));
        end
    endtask

    task automatic wait_valid(string name, int idx);
        int lim = 0;
        while (!(out_valid && out_index == AW'(idx)) && lim < 200) begin
            tick();
            lim++;
        end
        if (!(out_valid && out_index == AW'(idx))) fail_now(name);
    endtask

    initial begin
        int d0;
        // Reset state.
        #2;
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_addr", DW'(rf_addr), DW'(0));
        chk("rst_data", out_data, DW'(0));
        tick(2);
        rst_n = 1'b1;
        tick();

        // 1: full dump of r[i] = i*3.
        for (int i = 0; i < NR; i++) rf_write(i, DW'(i * 3));
        start_dump(0, 31);
        wait_done("full", 32, 1'b1);

        // 2: backpressure on the first beat of 4..6.
        rf_write(4, DW'(5890));
        out_ready = 1'b0;
        start_dump(4, 6);
        wait_valid("bp_first_valid", 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", DW'(out_valid), DW'(1));
            chk("bp_data", out_data, DW'(5890));
            chk("bp_index", DW'(out_index), DW'(4));
            tick();
        end
        out_ready = 1'b1;
        wait_done("bp", 3, 1'b0);

        // 3: wrapping range and single-register range.
        start_dump(30, 1);
        wait_done("wrap", 4, 1'b1);
        start_dump(31, 31);
        wait_done("single", 1, 1'b1);

        // 4: start while busy is ignored.
        start_dump(0, 3);
        tick(3);
        first_addr = AW'(10); last_addr = AW'(12); start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start", 4, 1'b1);
        d0 = done_cnt;
        tick(10);
        chk("busy_start_no_extra_done", DW'(done_cnt - d0), DW'(0));

        // 5: abort coinciding with the handshake of index 2 in a 0..7 dump.
        d0 = done_cnt;
        start_dump(0, 7, 3);
        wait_valid("abort_reach_2", 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", DW'(out_valid), DW'(0));
        chk("abort_busy", DW'(busy), DW'(0));
        tick(20);
        chk("abort_no_done", DW'(done_cnt - d0), DW'(0));
        chk("abort_queue", DW'(exp_q.size()), DW'(0));
        start_dump(5, 7);
        wait_done("abort_restart", 3, 1'b1);

        // 6: asynchronous reset mid-dump, between clock edges.
        out_ready = 1'b0;
        start_dump(0, 7, 0);
        wait_valid("rst_reach_0", 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", DW'(out_valid), DW'(0));
        chk("arst_busy", DW'(busy), DW'(0));
        chk("arst_done", DW'(done), DW'(0));
        chk("arst_index", DW'(out_index), DW'(0));
        tick(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(10);
        chk("arst_idle_valid", DW'(out_valid), DW'(0));
        chk("arst_idle_busy", DW'(busy), DW'(0));
        start_dump(2, 3);
        wait_done("arst_restart", 2, 1'b1);

        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
